// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder/subtractor. A single 4-bit carry-lookahead slice is reused for
// WIDTH/4 cycles, with the carry held in a register between nibbles.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             a_msb_q, b_msb_q;
  logic             ovf_q, valid_q;

  logic [WIDTH-1:0] b_eff;
  logic [3:0]       g, p, sl_sum;
  logic [4:0]       c;
  logic [WIDTH+3:0] sum_cat;

  assign b_eff = sub ? ~b : b;

  // Carry-lookahead slice: every carry is a flat function of g, p and the registered carry.
  always_comb begin
    g    = a_q[3:0] & b_q[3:0];
    p    = a_q[3:0] ^ b_q[3:0];
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sl_sum = p ^ c[3:0];
  end

  // New nibble enters at the top; the concatenation keeps this valid for WIDTH=4 too.
  assign sum_cat = {sl_sum, sum_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= sub ? 1'b1 : cin;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b_eff[WIDTH-1];
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          sum_q   <= sum_cat[WIDTH+3:4];
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= c[4];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            valid_q <= 1'b1;
            ovf_q   <= (a_msb_q == b_msb_q) && (sl_sum[3] != a_msb_q);
          end
        end
        StDone: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign overflow  = ovf_q;

endmodule
